// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and the flag bundle type for the ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Opcodes that route through the shared adder in subtract mode.
  function automatic logic uses_subtract(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

  // Only ADD and SUB report carry and overflow in the flag register.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder: sum = a + (sub ? ~b : b) + sub, with carry-out and signed overflow.
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full_sum;

  always_comb begin
    b_eff    = sub_i ? ~b_i : b_i;
    full_sum = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
  end

  assign sum_o  = full_sum[WIDTH-1:0];
  assign cout_o = full_sum[WIDTH];
  // Comparing against the inverted B covers both the ADD and SUB overflow rules.
  assign ovf_o  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// 32-bit combinational ALU with a clocked {N,Z,C,V} status-flag register.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       ALUControl,
  input  logic             flagWrite,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             sub_en;
  logic             slt_bit;
  logic             sltu_bit;
  logic [3:0]       flags_d;
  logic [3:0]       flags_q;

  assign sub_en = uses_subtract(ALUControl);

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a_i    (srcA),
    .b_i    (srcB),
    .sub_i  (sub_en),
    .sum_o  (sum),
    .cout_o (cout),
    .ovf_o  (ovf)
  );

  // Signed less-than stays correct across overflow; unsigned is a borrow.
  assign slt_bit  = sum[WIDTH-1] ^ ovf;
  assign sltu_bit = ~cout;

  always_comb begin
    result = 'x;
    unique case (ALUControl)
      ALU_ADD:  result = sum;
      ALU_SUB:  result = sum;
      ALU_AND:  result = srcA & srcB;
      ALU_OR:   result = srcA | srcB;
      ALU_XOR:  result = srcA ^ srcB;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, sltu_bit};
      ALU_SLL:  result = srcA << srcB[4:0];
      default:  result = 'x;
    endcase
  end

  assign zero = (result == '0);

  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_N] = result[WIDTH-1];
    flags_d[FLAG_Z] = zero;
    flags_d[FLAG_C] = is_arith(ALUControl) & cout;
    flags_d[FLAG_V] = is_arith(ALUControl) & ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else if (flagWrite) begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues reference results, a negedge monitor checks them.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic [3:0]  exp_flags;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic [2:0]  ALUControl = 3'b000;
  logic        flagWrite = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  flags;

  item_t       sb_q[$];
  logic [3:0]  mflags = 4'b0000;
  int          checks = 0;
  int          errors = 0;

  alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .srcA       (srcA),
    .srcB       (srcB),
    .ALUControl (ALUControl),
    .flagWrite  (flagWrite),
    .result     (result),
    .zero       (zero),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operation meanings, not on adder internals.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op,
                                    output logic [31:0] r, output logic [3:0] f);
    longint ss;
    logic   c;
    logic   v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        r  = a + b;
        c  = (longint'(a) + longint'(b)) > 64'sh0_FFFF_FFFF;
        ss = longint'($signed(a)) + longint'($signed(b));
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd1: begin
        r  = a - b;
        c  = (a >= b);
        ss = longint'($signed(a)) - longint'($signed(b));
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: r = (a < b) ? 32'd1 : 32'd0;
      default: r = a << b[4:0];
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  // Drive one vector just after a rising edge; reset/flagWrite hold through the next edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic fw, input logic rst);
    item_t      it;
    logic [31:0] r;
    logic [3:0]  nf;
    @(posedge clk);
    #1;
    srcA       = a;
    srcB       = b;
    ALUControl = op;
    flagWrite  = fw;
    reset      = rst;
    ref_model(a, b, op, r, nf);
    if (rst) mflags = 4'b0000;
    it.a          = a;
    it.b          = b;
    it.op         = op;
    it.exp_result = r;
    it.exp_zero   = (r == 32'd0);
    it.exp_flags  = mflags;
    sb_q.push_back(it);
    if (!rst && fw) mflags = nf;
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        checks++;
        if (result !== it.exp_result) begin
          errors++;
          $display("FAIL result op=%0d a=%h b=%h got %h expected %h",
                   it.op, it.a, it.b, result, it.exp_result);
        end
        checks++;
        if (zero !== it.exp_zero) begin
          errors++;
          $display("FAIL zero op=%0d a=%h b=%h got %b expected %b",
                   it.op, it.a, it.b, zero, it.exp_zero);
        end
        checks++;
        if (flags !== it.exp_flags) begin
          errors++;
          $display("FAIL flags op=%0d a=%h b=%h got %b expected %b",
                   it.op, it.a, it.b, flags, it.exp_flags);
        end
      end
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin : driver
    logic [31:0] a;
    issue(32'd0, 32'd0, ALU_ADD, 1'b1, 1'b1);
    issue(32'd15, 32'd10, ALU_ADD, 1'b0, 1'b0);
    issue(32'd20, 32'd5, ALU_SUB, 1'b0, 1'b0);
    issue(32'h0F0F0F0F, 32'h00FF00FF, ALU_AND, 1'b0, 1'b0);
    issue(32'h0F0F0F0F, 32'h00FF00FF, ALU_OR, 1'b0, 1'b0);
    issue(32'h0F0F0F0F, 32'h00FF00FF, ALU_XOR, 1'b0, 1'b0);
    issue(32'd5, 32'd10, ALU_SLT, 1'b0, 1'b0);
    issue(32'd10, 32'd5, ALU_SLT, 1'b0, 1'b0);
    issue(32'hFFFFFFFF, 32'd1, ALU_SLT, 1'b0, 1'b0);
    issue(32'hFFFFFFFF, 32'd1, ALU_SLTU, 1'b0, 1'b0);
    issue(32'h80000000, 32'd1, ALU_SLT, 1'b0, 1'b0);
    issue(32'h00000001, 32'h00000024, ALU_SLL, 1'b0, 1'b0);
    issue(32'h7FFFFFFF, 32'd1, ALU_ADD, 1'b1, 1'b0);
    issue(32'd7, 32'd7, ALU_SUB, 1'b1, 1'b0);
    issue(32'd3, 32'd9, ALU_XOR, 1'b0, 1'b0);
    issue(32'd12, 32'd34, ALU_ADD, 1'b0, 1'b0);
    // Reset raised mid-cycle with flags at 0110, held across an edge with flagWrite high.
    issue(32'd1, 32'd2, ALU_OR, 1'b1, 1'b1);
    issue(32'hFFFFFFFF, 32'd1, ALU_ADD, 1'b1, 1'b1);
    issue(32'd4, 32'd4, ALU_SUB, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      a = pick_operand();
      issue(a, ($urandom_range(0, 5) == 0) ? a : pick_operand(),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 40) == 0));
    end
    issue(32'd0, 32'd0, ALU_AND, 1'b0, 1'b0);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit arithmetic/logic unit for the single-cycle datapath.
- Computes the selected operation on srcA/srcB combinationally.
- Also holds a 4-bit status-flag register (N, Z, C, V), captured on the clock when enabled, for later conditional logic.
- The datapath result path is purely combinational. Only the flag register uses clk/reset.

Parameters:
- WIDTH, 32, operand and result width in bits. Only 32 is supported by the opcode set; the shift amount uses the low 5 bits.

Ports:
- clk  input  1  system clock; flag register updates on the rising edge
- reset  input  1  asynchronous, active-high; clears the flag register
- srcA  input  WIDTH  operand A
- srcB  input  WIDTH  operand B
- ALUControl  input  3  operation select
- flagWrite  input  1  when high, the flag register captures the current flags at the next rising clk
- result  output  WIDTH  combinational operation result
- zero  output  1  combinational; high when result == 0
- flags  output  4  registered {N,Z,C,V}

Behaviour:
- ALUControl encoding:
  - 000 ADD: srcA+srcB mod 2^32
  - 001 SUB: srcA-srcB, computed as srcA+~srcB+1
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT signed: result = {31'b0, (srcA <s srcB)}
  - 110 SLTU unsigned: result = {31'b0, (srcA <u srcB)}
  - 111 SLL: srcA << srcB[4:0], zero-filled
- SLT uses a true signed compare: sign of difference XOR overflow. It is correct across overflow, e.g. 0x80000000 < 0x00000001 gives 1.
- SLTU = NOT carry-out of the subtraction.
- result and zero are combinational, zero latency, and have no dependence on clk/reset. They settle within the same delta after the inputs change.
- Next-flag values:
  - N = result[31]
  - Z = (result == 0)
  - C = adder carry-out for ADD/SUB, 0 for all other ops. For SUB, C=1 means no borrow (srcA >=u srcB).
  - V = signed overflow for ADD/SUB, 0 otherwise. ADD: operand signs equal and result sign differs. SUB: operand signs differ and result sign differs from srcA.
- Flag register:
  - reset high → flags = 4'b0000 immediately, asynchronously, and held while reset is asserted.
  - On rising clk with reset low and flagWrite=1 → flags takes the next-flag values.
  - flagWrite=0 → flags holds its value.
- Reset deasserting coincident with a clk edge: the register stays 0 for that edge.
- reset has no effect on result or zero.
- Any X on ALUControl drives result to all X. There is no default silent value.

Decomposition:
- Package alu_pkg: the 3-bit opcode localparams ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, and the flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, alu_addsub:
  - Function: shared 32-bit adder with an invert-B/carry-in control; outputs sum, carry-out and overflow.
  - Users: ADD, SUB, SLT and SLTU.
  - Why: avoids duplicate adders.
- The flag register stays in the top module.

Test Plan:
- ADD: srcA=15, srcB=10, ALUControl=000 → result=25, zero=0. SUB: srcA=20, srcB=5, ALUControl=001 → result=15.
- AND: srcA=0x0F0F0F0F, srcB=0x00FF00FF, ALUControl=010 → 0x000F000F. OR (011) with the same operands → 0x0FFF0FFF. XOR (100) → 0x0FF00FF0.
- SLT: srcA=5, srcB=10, ALUControl=101 → result=1.
  - Swapped operands → 0.
  - srcA=0xFFFFFFFF, srcB=1: SLT → 1, SLTU (110) → 0.
- SLL: srcA=0x00000001, srcB=0x00000024, ALUControl=111 → 0x00000010 (only srcB[4:0]=4 is used).
- Flags, each captured with flagWrite=1 on one clk:
  - reset pulse → flags=0000.
  - ADD 0x7FFFFFFF+1 → result=0x80000000, flags=1001 (N,V).
  - SUB 7-7 → result=0, zero=1, flags=0110 (Z,C).
  - Next cycle with flagWrite=0 and different operands → flags unchanged.
- Asynchronous reset: assert reset mid-cycle between clk edges with flags=0110 → flags=0000 before the next edge. result keeps tracking the inputs throughout.
